// File: rtl/tt_um_hoene_protocol_sequencer.sv
`default_nettype none
// ============================================================================
// tt_um_hoene_protocol_sequencer: LED stream frame sequencer. It captures the
// own word, gates forwarding and reports per-frame status. Rev 1.0
// ============================================================================
module tt_um_hoene_protocol_sequencer #(
  parameter int WORD_BITS = 25,
  parameter int COUNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_data,
  input  logic                 in_clk,
  input  logic                 in_sync,
  output logic [4:0]           bit_counter,
  output logic [WORD_BITS-2:0] own_data,
  output logic                 own_valid,
  output logic                 fwd_en,
  output logic [COUNT_W-1:0]   word_count,
  output logic                 frame_error,
  output logic                 frame_done,
  output logic                 frame_ok
);

  localparam logic [4:0]         LAST_BIT  = 5'(WORD_BITS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, OWN, FWD, ERR} state_t;

  state_t                 state, state_nx, cur_state;
  logic [WORD_BITS-1:0]   shift_q, shift_nx;
  logic                   parity_q, parity_nx, parity_w;
  logic [4:0]             bit_nx;
  logic [WORD_BITS-2:0]   own_data_nx;
  logic                   own_valid_nx, fwd_en_nx, frame_error_nx;
  logic                   frame_done_nx, frame_ok_nx;
  logic [COUNT_W-1:0]     word_count_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_counter <= '0;
      own_data    <= '0;
      own_valid   <= 1'b0;
      fwd_en      <= 1'b0;
      word_count  <= '0;
      frame_error <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
    end else begin
      state       <= state_nx;
      shift_q     <= shift_nx;
      parity_q    <= parity_nx;
      bit_counter <= bit_nx;
      own_data    <= own_data_nx;
      own_valid   <= own_valid_nx;
      fwd_en      <= fwd_en_nx;
      word_count  <= word_count_nx;
      frame_error <= frame_error_nx;
      frame_done  <= frame_done_nx;
      frame_ok    <= frame_ok_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    shift_nx       = shift_q;
    parity_nx      = parity_q;
    bit_nx         = bit_counter;
    own_data_nx    = own_data;
    own_valid_nx   = 1'b0;
    fwd_en_nx      = fwd_en;
    word_count_nx  = word_count;
    frame_error_nx = frame_error;
    frame_done_nx  = 1'b0;
    frame_ok_nx    = frame_ok;
    // The first sample out of IDLE is handled as the first bit of the own word
    cur_state      = (state == IDLE) ? OWN : state;
    parity_w       = parity_q ^ in_data;

    if (!in_sync) begin
      // A strobe coinciding with the falling sync is dropped; the frame closes as-is
      if (state != IDLE) begin
        frame_done_nx  = 1'b1;
        frame_ok_nx    = !frame_error && (bit_counter == 5'd0) && (word_count != '0);
        state_nx       = IDLE;
        shift_nx       = '0;
        parity_nx      = 1'b0;
        bit_nx         = 5'd0;
        fwd_en_nx      = 1'b0;
        word_count_nx  = '0;
        frame_error_nx = 1'b0;
      end
    end else if (in_clk) begin
      state_nx = cur_state;
      shift_nx = {shift_q[WORD_BITS-2:0], in_data};
      if (bit_counter == LAST_BIT) begin
        bit_nx    = 5'd0;
        parity_nx = 1'b0;
        if (word_count != COUNT_MAX) begin
          word_count_nx = word_count + COUNT_W'(1);
        end
        if (parity_w) begin
          state_nx       = ERR;
          frame_error_nx = 1'b1;
        end else if (cur_state == OWN) begin
          own_data_nx  = shift_nx[WORD_BITS-1:1];
          own_valid_nx = 1'b1;
          fwd_en_nx    = 1'b1;
          state_nx     = FWD;
        end
      end else begin
        bit_nx    = bit_counter + 5'd1;
        parity_nx = parity_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_hoene_protocol_sequencer.sv
`default_nettype none
// Testbench for tt_um_hoene_protocol_sequencer: directed and random frames
// checked every cycle against a bit-queue level frame model.
module tb_tt_um_hoene_protocol_sequencer;
  localparam int W  = 25;
  localparam int CW = 8;

  logic clk = 1'b0, rst_n = 1'b0, in_data = 1'b0, in_clk = 1'b0, in_sync = 1'b0;
  logic [4:0]    bit_counter;
  logic [W-2:0]  own_data;
  logic          own_valid, fwd_en, frame_error, frame_done, frame_ok;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  tt_um_hoene_protocol_sequencer #(.WORD_BITS(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk), .in_sync(in_sync),
    .bit_counter(bit_counter), .own_data(own_data), .own_valid(own_valid),
    .fwd_en(fwd_en), .word_count(word_count), .frame_error(frame_error),
    .frame_done(frame_done), .frame_ok(frame_ok)
  );

  int n_cmp = 0, n_bad = 0;

  // Frame model: bits seen in the current word, total words in the frame, flags
  int          m_bits, m_total;
  logic [31:0] m_cur;
  logic [W-2:0] m_own;
  logic        m_err, m_fwd, m_active, m_own_valid, m_done, m_ok;

  logic [2:0] stim[$];  // {in_sync, in_clk, in_data} per cycle

  task automatic model_reset();
    m_bits = 0; m_total = 0; m_cur = '0; m_own = '0;
    m_err = 0; m_fwd = 0; m_active = 0; m_own_valid = 0; m_done = 0; m_ok = 0;
  endtask

  task automatic model_step(input logic s, input logic c, input logic d);
    m_own_valid = 0;
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!s) begin
      if (m_active) begin
        m_done = 1;
        m_ok = !m_err && (m_bits == 0) && (m_total != 0);
        m_bits = 0; m_total = 0; m_err = 0; m_fwd = 0; m_cur = '0; m_active = 0;
      end
    end else if (c) begin
      m_active = 1;
      m_cur = {m_cur[30:0], d};
      m_bits++;
      if (m_bits == W) begin
        m_total++;
        m_bits = 0;
        if ($countones(m_cur[W-1:0]) % 2 == 1) m_err = 1;
        else if (m_total == 1) begin
          m_own = m_cur[W-1:1];
          m_own_valid = 1;
          m_fwd = 1;
        end
        m_cur = '0;
      end
    end
  endtask

  function automatic logic [41:0] exp_vec();
    return {5'(m_bits), m_own_valid, m_fwd, (m_total > 255) ? 8'hFF : 8'(m_total),
            m_err, m_done, m_ok, m_own};
  endfunction

  function automatic logic [41:0] act_vec();
    return {bit_counter, own_valid, fwd_en, word_count, frame_error, frame_done, frame_ok, own_data};
  endfunction

  task automatic drive(input logic s, input logic c, input logic d);
    @(negedge clk);
    in_sync = s; in_clk = c; in_data = d;
    @(posedge clk);
    model_step(s, c, d);
    #1;
  endtask

  task automatic push_word(input logic [W-2:0] data, input logic p);
    for (int i = W - 2; i >= 0; i--) stim.push_back({2'b11, data[i]});
    stim.push_back({2'b11, p});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0);
    drive(1, 1, 1);
    n_cmp++;
    if (act_vec() !== 42'd0) begin
      n_bad++; $display("FAIL reset: got %h want %h", act_vec(), 42'd0);
    end
    rst_n = 1'b1;
    drive(0, 0, 0);
  endtask

  task automatic test_single_frame();
    stim.delete();
    push_word(24'hA5A5A5, 1'b0);
    foreach (stim[i]) begin
      drive(stim[i][2], stim[i][1], stim[i][0]);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL single cycle %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      n_cmp++;
      if (bit_counter !== 5'((i + 1) % W) || own_valid !== (i == W - 1)) begin
        n_bad++; $display("FAIL single_seq bit %0d: got bc=%0d ov=%b want bc=%0d ov=%b",
                          i, bit_counter, own_valid, (i + 1) % W, i == W - 1);
      end
    end
    n_cmp++;
    if (own_data !== 24'hA5A5A5 || fwd_en !== 1'b1 || word_count !== 8'd1) begin
      n_bad++; $display("FAIL single_word: got od=%h fe=%b wc=%0d want od=a5a5a5 fe=1 wc=1",
                        own_data, fwd_en, word_count);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_ok !== 1'b1) begin
      n_bad++; $display("FAIL single_done: got done=%b ok=%b want done=1 ok=1", frame_done, frame_ok);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b0 || fwd_en !== 1'b0 || word_count !== 8'd0) begin
      n_bad++; $display("FAIL single_clear: got done=%b fe=%b wc=%0d want 0 0 0", frame_done, fwd_en, word_count);
    end
  endtask

  task automatic test_forwarding();
    int pulses = 0;
    stim.delete();
    push_word(24'hA5A5A5, 1'b0);
    push_word(24'h000001, 1'b1);
    push_word(24'hFFFFFF, 1'b0);
    stim.push_back(3'b000);
    foreach (stim[i]) begin
      drive(stim[i][2], stim[i][1], stim[i][0]);
      pulses += int'(own_valid);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL fwd cycle %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 3 * W - 1) begin
        n_cmp++;
        if (word_count !== 8'd3 || fwd_en !== 1'b1 || own_data !== 24'hA5A5A5) begin
          n_bad++; $display("FAIL fwd_words: got wc=%0d fe=%b od=%h want 3 1 a5a5a5", word_count, fwd_en, own_data);
        end
      end
    end
    n_cmp++;
    if (pulses !== 1 || frame_ok !== 1'b1) begin
      n_bad++; $display("FAIL fwd_once: got pulses=%0d ok=%b want 1 1", pulses, frame_ok);
    end
  endtask

  task automatic test_parity_error();
    stim.delete();
    push_word(24'hA5A5A5, 1'b0);
    push_word(24'h000001, 1'b0);
    push_word(24'hA5A5A5, 1'b0);
    stim.push_back(3'b000);
    stim.push_back(3'b000);
    foreach (stim[i]) begin
      drive(stim[i][2], stim[i][1], stim[i][0]);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL perr cycle %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 2 * W - 1 || i == 3 * W - 1) begin
        n_cmp++;
        if (frame_error !== 1'b1) begin
          n_bad++; $display("FAIL perr_flag bit %0d: got %b want 1", i + 1, frame_error);
        end
      end
      if (i == 3 * W) begin
        n_cmp++;
        if (frame_done !== 1'b1 || frame_ok !== 1'b0 || frame_error !== 1'b0) begin
          n_bad++; $display("FAIL perr_done: got done=%b ok=%b err=%b want 1 0 0", frame_done, frame_ok, frame_error);
        end
      end
    end
  endtask

  task automatic test_own_error();
    int pulses = 0;
    stim.delete();
    push_word(24'h000001, 1'b0);
    stim.push_back(3'b000);
    foreach (stim[i]) begin
      drive(stim[i][2], stim[i][1], stim[i][0]);
      pulses += int'(own_valid);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL own_err cycle %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (pulses !== 0 || own_data !== 24'hA5A5A5 || frame_ok !== 1'b0 || frame_done !== 1'b1) begin
      n_bad++; $display("FAIL own_err_end: got pulses=%0d od=%h ok=%b done=%b want 0 a5a5a5 0 1",
                        pulses, own_data, frame_ok, frame_done);
    end
  endtask

  task automatic test_truncated();
    for (int i = 0; i < 10; i++) drive(1, 1, 1'(i & 1));
    n_cmp++;
    if (bit_counter !== 5'd10) begin
      n_bad++; $display("FAIL trunc_count: got %0d want 10", bit_counter);
    end
    drive(0, 1, 1);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_ok !== 1'b0 || word_count !== 8'd0 || bit_counter !== 5'd0) begin
      n_bad++; $display("FAIL trunc_done: got done=%b ok=%b wc=%0d bc=%0d want 1 0 0 0",
                        frame_done, frame_ok, word_count, bit_counter);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL trunc_after: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 12; i++) drive(1, 1, 1'(i % 3 == 0));
    rst_n = 1'b0;
    drive(1, 1, 1);
    n_cmp++;
    if (act_vec() !== 42'd0) begin
      n_bad++; $display("FAIL mid_reset: got %h want %h", act_vec(), 42'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'(i & 1), 1);
      n_cmp++;
      if (frame_done !== 1'b0 || bit_counter !== 5'd0 || act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL idle_strobe %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    stim.delete();
    repeat (300) push_word(24'hA5A5A5, 1'b0);
    foreach (stim[i]) begin
      drive(stim[i][2], stim[i][1], stim[i][0]);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL sat cycle %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (word_count !== 8'hFF) begin
      n_bad++; $display("FAIL sat_count: got %0d want 255", word_count);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_ok !== 1'b1) begin
      n_bad++; $display("FAIL sat_done: got done=%b ok=%b want 1 1", frame_done, frame_ok);
    end
  endtask

  task automatic test_random_frames();
    logic [31:0] data;
    logic        p;
    repeat (30) begin
      stim.delete();
      if ($urandom_range(0, 1) == 1) stim.push_back({2'b10, 1'($urandom)});
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        data = $urandom;
        p = (^data[W-2:0]) ^ ($urandom_range(0, 7) == 0);
        for (int b = W - 2; b >= -1; b--) begin
          if ($urandom_range(0, 3) == 0) stim.push_back({2'b10, 1'($urandom)});
          stim.push_back({2'b11, (b < 0) ? p : data[b]});
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, W)); k++) void'(stim.pop_back());
      end
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) stim.push_back({1'b0, 2'($urandom)});
      foreach (stim[i]) begin
        drive(stim[i][2], stim[i][1], stim[i][0]);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL random cycle %0d: got %h want %h", i, act_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_forwarding();
    test_parity_error();
    test_own_error();
    test_truncated();
    test_reset_mid_frame();
    test_saturation();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
